// File: rtl/alu_exec_if.sv
// Valid/ready request and result channel of the EX-stage execute unit.
interface alu_exec_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, alu_control, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_control, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec.sv
// Execute unit: single-cycle logic/arith ops plus an iterative shift-add MUL,
// returning a registered result with zero/illegal flags over valid/ready.
module alu_exec #(
  parameter int unsigned WIDTH = 32
) (
  input  logic      clk,
  input  logic      reset,
  alu_exec_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  typedef enum logic [3:0] {
    OP_OR  = 4'b0000,
    OP_AND = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0100,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_MUL = 4'b1000
  } op_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] single_res;
  logic             single_ill;
  logic [WIDTH-1:0] mul_sum;

  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    single_res = '0;
    single_ill = 1'b0;
    case (bus.alu_control)
      OP_OR:   single_res = bus.op_a | bus.op_b;
      OP_AND:  single_res = bus.op_a & bus.op_b;
      OP_ADD:  single_res = bus.op_a + bus.op_b;
      OP_XOR:  single_res = bus.op_a ^ bus.op_b;
      OP_SUB:  single_res = bus.op_a - bus.op_b;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      default: single_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    illegal_d   = illegal_q;

    // Drain first; a result written on the same edge overrides it below.
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.alu_control == OP_MUL) begin
            state_d  = S_MUL;
            mcand_d  = bus.op_a;
            mplier_d = bus.op_b;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH);
          end else begin
            result_d    = single_res;
            zero_d      = (single_res == '0);
            illegal_d   = single_ill;
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = S_IDLE;
          result_d    = mul_sum;
          zero_d      = (mul_sum == '0);
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;
endmodule
